// File: rtl/ctrl_decode_stage.sv
// ID-stage control decoder for RV32I with a registered ID/EX control slot,
// load-use bubble insertion, flush and hold. Optional counters: CTRL_PERF_EN.
module ctrl_decode_stage #(
  parameter int unsigned        ALUOP_W    = 2,
  parameter int unsigned        RA_W       = 5,
  parameter logic [ALUOP_W-1:0] ALUOP_IALU = ALUOP_W'(2'b11)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [31:0]        id_instr,
  input  logic               flush,
  input  logic               ex_hold,
`ifdef CTRL_PERF_EN
  input  logic               perf_clr,
  output logic [31:0]        perf_stalls,
  output logic [31:0]        perf_flushes,
`endif
  output logic               stall_if,
  output logic               ex_valid,
  output logic [RA_W-1:0]    ex_rd,
  output logic               ex_RegWrite,
  output logic               ex_MemtoReg,
  output logic               ex_MemRead,
  output logic               ex_MemWrite,
  output logic               ex_Branch,
  output logic               ex_ALUSrc,
  output logic               ex_Jump,
  output logic               ex_Link,
  output logic [ALUOP_W-1:0] ex_ALUOp,
  output logic               ex_illegal
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [ALUOP_W-1:0] ALUOP_MEM = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALUOP_BR  = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALUOP_R   = ALUOP_W'(2'b10);

  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic               alu_src;
    logic               jump;
    logic               link;
    logic [ALUOP_W-1:0] alu_op;
    logic               illegal;
  } ctrl_t;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    ctrl_t           ctrl;
  } slot_t;

  logic [6:0]      opcode;
  logic [RA_W-1:0] rd, rs1, rs2;
  ctrl_t           dec;
  logic            use_rs1, use_rs2, has_rd;
  logic            hz;
  slot_t           nxt, q;
  logic            unused_instr_bits;

  assign opcode = id_instr[6:0];
  assign rd     = RA_W'(id_instr[11:7]);
  assign rs1    = RA_W'(id_instr[19:15]);
  assign rs2    = RA_W'(id_instr[24:20]);
  assign unused_instr_bits = ^{id_instr[31:25], id_instr[14:12]};

  // Opcode decode: control bundle plus which source/destination fields are live
  always_comb begin
    dec     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    has_rd  = 1'b1;
    case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = ALUOP_R;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OP_IALU: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALUOP_IALU;
        use_rs1       = 1'b1;
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.mem_read   = 1'b1;
        dec.alu_op     = ALUOP_MEM;
        use_rs1        = 1'b1;
      end
      OP_STORE: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_op    = ALUOP_MEM;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        has_rd        = 1'b0;
      end
      OP_BR: begin
        dec.branch = 1'b1;
        dec.alu_op = ALUOP_BR;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        has_rd     = 1'b0;
      end
      OP_JAL: begin
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.link      = 1'b1;
      end
      OP_JALR: begin
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.link      = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALUOP_MEM;
        use_rs1       = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALUOP_MEM;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Load in EX whose destination is read by the ID instruction
  assign hz = id_valid & q.valid & q.ctrl.mem_read & (q.rd != '0) &
              ((use_rs1 & (rs1 == q.rd)) | (use_rs2 & (rs2 == q.rd)));

  assign stall_if = (hz | ex_hold) & ~flush & ~rst;

  // Invalid ID slot loads an all-zero bundle
  always_comb begin
    nxt = '0;
    if (id_valid) begin
      nxt.valid = 1'b1;
      nxt.rd    = has_rd ? rd : '0;
      nxt.ctrl  = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          q <= '0;
    else if (flush)   q <= '0;
    else if (ex_hold) q <= q;
    else if (hz)      q <= '0;
    else              q <= nxt;
  end

  assign ex_valid    = q.valid;
  assign ex_rd       = q.rd;
  assign ex_RegWrite = q.ctrl.reg_write;
  assign ex_MemtoReg = q.ctrl.mem_to_reg;
  assign ex_MemRead  = q.ctrl.mem_read;
  assign ex_MemWrite = q.ctrl.mem_write;
  assign ex_Branch   = q.ctrl.branch;
  assign ex_ALUSrc   = q.ctrl.alu_src;
  assign ex_Jump     = q.ctrl.jump;
  assign ex_Link     = q.ctrl.link;
  assign ex_ALUOp    = q.ctrl.alu_op;
  assign ex_illegal  = q.ctrl.illegal;

`ifdef CTRL_PERF_EN
  // Event counters; clear beats increment
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      perf_stalls  <= '0;
      perf_flushes <= '0;
    end else begin
      if (flush)                 perf_flushes <= perf_flushes + 32'd1;
      if (hz && !ex_hold && !flush) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule
